// File: rtl/encoder_scan.sv
// encoder_scan: sequential 8-to-3 encoder, the reverse of the 3-to-8 decoder.
// It accepts one vector with zero or more set bits. It then emits the index of
// each set bit, one per output beat, starting with the lowest index.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   producer presents `in`
//   in_ready   block can accept a vector (IDLE and not in reset)
//   in         request vector, sampled only at accept
//   out_valid  out / out_none / out_last are valid (SCAN)
//   out_ready  consumer accepts the current beat
//   out        index of the lowest bit still pending
//   out_none   beat reports an all-zero input vector
//   out_last   final beat for the current vector
//
// WIDTH must equal 2**OUT_W.
module encoder_scan #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_none,
    output logic             out_last
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             none_q, none_d;
    logic [OUT_W-1:0] low_idx;
    logic             single;
    logic             beat;

    // Find the lowest set bit of pending. The loop scans downward, so the
    // last assignment made is the one for the lowest index. An empty pending
    // register gives index 0, which is the value the zero-vector beat reports.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_q[i]) low_idx = OUT_W'(i);
        end
    end

    // The vector has exactly one set bit when it is non-zero and clearing its
    // lowest set bit leaves nothing.
    assign single = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);

    assign out_valid = (state_q == SCAN);
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out       = low_idx;
    assign out_none  = (state_q == SCAN) && none_q;
    assign out_last  = (state_q == SCAN) && (none_q || single);
    assign beat      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        none_d  = none_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SCAN;
                    pend_d  = in;
                    none_d  = (in == '0);
                end
            end
            SCAN: begin
                if (beat) begin
                    pend_d = pend_q & (pend_q - WIDTH'(1));
                    if (out_last) begin
                        state_d = IDLE;
                        none_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            none_q  <= none_d;
        end
    end

endmodule

// File: tb/tb_encoder_scan.sv
module tb_encoder_scan;

    typedef struct packed {
        logic [2:0] idx;
        logic       none;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out;
    logic       out_none;
    logic       out_last;

    beat_t exp_q[$];
    int    chk_cnt = 0;
    int    pass_cnt = 0;

    encoder_scan #(.WIDTH(8), .OUT_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_none(out_none), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Push the expected beats for one vector, lowest index first.
    function automatic void push_vec(input logic [7:0] v);
        beat_t b;
        logic [7:0] above;
        if (v == 8'h00) begin
            b.idx = 3'd0; b.none = 1'b1; b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    above = v >> (i + 1);
                    b.idx = 3'(i); b.none = 1'b0; b.last = (above == 8'h00);
                    exp_q.push_back(b);
                end
            end
        end
    endfunction

    // Present one vector for a single accept edge. The block is idle here.
    task automatic send(input logic [7:0] v);
        in = v;
        in_valid = 1'b1;
        push_vec(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if ({out_valid, in_ready, out, out_none, out_last} !== 7'b0)
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {out_valid, in_ready, out, out_none, out_last});
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_two_bits();
        beat_t e;
        int cyc;
        out_ready = 1'b1;
        send(8'b0010_0100);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk_cnt++;
                if ({out, out_none, out_last} !== e)
                    $display("FAIL two_bits_beat: got %b expected %b", {out, out_none, out_last}, e);
                else pass_cnt++;
                chk_cnt++;
                if (in_ready !== 1'b0)
                    $display("FAIL two_bits_in_ready: got %b expected 0", in_ready);
                else pass_cnt++;
            end
            @(posedge clk); #1; cyc++;
        end
        chk_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL two_bits_timeout: %0d beats missing expected 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL two_bits_idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_one_hot();
        beat_t e;
        int cyc;
        logic [7:0] dec, want;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(8'h01 << i);
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 20) begin
                if (out_valid && out_ready) begin
                    e = exp_q.pop_front();
                    chk_cnt++;
                    if ({out, out_none, out_last} !== e)
                        $display("FAIL one_hot_%0d_beat: got %b expected %b", i, {out, out_none, out_last}, e);
                    else pass_cnt++;
                    // Round trip through a 3-to-8 decoder.
                    dec = 8'h01 << out;
                    want = 8'h01 << i;
                    chk_cnt++;
                    if (dec !== want)
                        $display("FAIL one_hot_%0d_decode: got %h expected %h", i, dec, want);
                    else pass_cnt++;
                end
                @(posedge clk); #1; cyc++;
            end
            chk_cnt++;
            if (exp_q.size() != 0 || out_valid !== 1'b0) begin
                $display("FAIL one_hot_%0d_end: pending=%0d out_valid=%b expected 0/0", i, exp_q.size(), out_valid);
                exp_q.delete();
            end else pass_cnt++;
        end
    endtask

    task automatic test_zero();
        beat_t e;
        int cyc;
        out_ready = 1'b1;
        send(8'h00);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk_cnt++;
                if ({out, out_none, out_last} !== e)
                    $display("FAIL zero_beat: got %b expected %b", {out, out_none, out_last}, e);
                else pass_cnt++;
            end
            @(posedge clk); #1; cyc++;
        end
        chk_cnt++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_none !== 1'b0) begin
            $display("FAIL zero_end: pending=%0d out_valid=%b in_ready=%b out_none=%b expected 0/0/1/0",
                     exp_q.size(), out_valid, in_ready, out_none);
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_full_stall();
        beat_t e;
        logic [4:0] held;
        logic had_stall;
        int cyc;
        send(8'hFF);
        cyc = 0;
        had_stall = 1'b0;
        while (exp_q.size() != 0 && cyc < 80) begin
            out_ready = (cyc % 3 == 0);
            if (out_valid) begin
                if (had_stall) begin
                    chk_cnt++;
                    if ({out, out_none, out_last} !== held)
                        $display("FAIL full_stall_hold: got %b expected %b", {out, out_none, out_last}, held);
                    else pass_cnt++;
                end
                if (out_ready) begin
                    e = exp_q.pop_front();
                    chk_cnt++;
                    if ({out, out_none, out_last} !== e)
                        $display("FAIL full_stall_beat: got %b expected %b", {out, out_none, out_last}, e);
                    else pass_cnt++;
                    had_stall = 1'b0;
                end else begin
                    held = {out, out_none, out_last};
                    had_stall = 1'b1;
                end
            end
            @(posedge clk); #1; cyc++;
        end
        chk_cnt++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            $display("FAIL full_stall_end: pending=%0d out_valid=%b expected 0/0", exp_q.size(), out_valid);
            exp_q.delete();
        end else pass_cnt++;
        out_ready = 1'b1;
    endtask

    task automatic test_input_stability();
        beat_t e;
        logic take;
        int cyc;
        out_ready = 1'b1;
        send(8'b1000_0001);
        // Second vector is held valid during the scan; it must wait for IDLE.
        in = 8'h3C;
        in_valid = 1'b1;
        push_vec(8'h3C);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk_cnt++;
                if ({out, out_none, out_last} !== e)
                    $display("FAIL stability_beat: got %b expected %b", {out, out_none, out_last}, e);
                else pass_cnt++;
            end
            take = in_valid && in_ready;
            @(posedge clk); #1; cyc++;
            if (take) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL stability_end: pending=%0d out_valid=%b in_ready=%b expected 0/0/1",
                     exp_q.size(), out_valid, in_ready);
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        beat_t e;
        logic seen;
        int cyc;
        out_ready = 1'b1;
        send(8'hF0);
        chk_cnt++;
        if (out_valid !== 1'b1 || out !== 3'd4 || out_last !== 1'b0)
            $display("FAIL mid_rst_first: valid=%b out=%0d last=%b expected 1/4/0", out_valid, out, out_last);
        else pass_cnt++;
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL mid_rst_held: out_valid=%b in_ready=%b expected 0/0", out_valid, in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL mid_rst_release: in_ready=%b expected 1", in_ready);
        else pass_cnt++;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk_cnt++;
        if (seen !== 1'b0)
            $display("FAIL mid_rst_no_beats: out_valid seen=%b expected 0", seen);
        else pass_cnt++;
        // A fresh vector must scan cleanly from an empty pending register.
        send(8'h02);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk_cnt++;
                if ({out, out_none, out_last} !== e)
                    $display("FAIL mid_rst_after: got %b expected %b", {out, out_none, out_last}, e);
                else pass_cnt++;
            end
            @(posedge clk); #1; cyc++;
        end
        chk_cnt++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            $display("FAIL mid_rst_end: pending=%0d out_valid=%b expected 0/0", exp_q.size(), out_valid);
            exp_q.delete();
        end else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_two_bits();
        test_one_hot();
        test_zero();
        test_full_stall();
        test_input_stability();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/encoder_scan.md
Name: encoder_scan

Overview:
- Sequential 8-to-3 encoder; inverse direction of the 3-to-8 `decoder` block.
- Accepts an 8-bit one-or-more-hot vector over a valid/ready handshake.
- Emits the 3-bit index of every set bit, one per output beat, lowest index first.
- Sits between request-vector producers and index-driven consumers. Output indices feed straight into `decoder` for round-trip checks.

Parameters:
- WIDTH, 8: input vector width. Must equal 2**OUT_W.
- OUT_W, 3: output index width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents `in`.
- in_ready  output  1  block can accept a vector.
- in  input  WIDTH  request vector.
- out_valid  output  1  `out` / `out_none` / `out_last` are valid.
- out_ready  input  1  consumer accepts current beat.
- out  output  OUT_W  index of the current set bit.
- out_none  output  1  beat reports an all-zero input vector.
- out_last  output  1  final beat for the current vector.

Behaviour:

Reset:
- Reset is synchronous and active-high on `rst`, single clock `clk`.
- While `rst` is sampled high: state goes to IDLE, pending register to 0, `out_valid` 0, `out` 0, `out_none` 0, `out_last` 0.
- `in_ready` is forced 0 while `rst` is high. It is 1 in IDLE after reset drops.
- Reset mid-scan discards remaining bits with no further beats.

States:
- IDLE: `in_ready` = 1, `out_valid` = 0.
- SCAN: `in_ready` = 0, `out_valid` = 1.

Accept:
- A vector is accepted when `in_valid` & `in_ready` at a rising edge.
- `in` is latched into the pending register and state moves to SCAN.
- First beat is valid the cycle after accept (latency 1).

Output beat contents (all registered or derived only from the pending register):
- `out` = lowest set bit index of pending.
- `out_last` = 1 iff pending has exactly one set bit.
- `out_none` = 0.

Zero vector:
- Accepting `in` = 0 produces exactly one beat: `out` = 0, `out_none` = 1, `out_last` = 1.

Beat handshake:
- Beat completes when `out_valid` & `out_ready`.
- On completion the lowest set bit is cleared from pending.
- If that beat had `out_last` = 1, go to IDLE, else stay in SCAN with the next index the following cycle.

Stall:
- While `out_valid` & !`out_ready`, `out`, `out_none` and `out_last` hold stable.
- Pending is unchanged during a stall.

Throughput:
- A vector with k set bits occupies k beats, plus 1 cycle to return to IDLE.
- A new vector is accepted no earlier than the cycle after the last beat completes. There is no overlap of accept and last beat.

Input stability:
- `in` is sampled only at accept. Changes to `in` while in SCAN are ignored.

Full vector:
- `in` = 8'hFF yields 8 beats, indices 0..7, with `out_last` only on index 7.

Test Plan:
1. Reset, then `in` = 8'b0010_0100 with `in_valid` = 1 and `out_ready` held 1 -> beats `out` = 2 (`last` = 0), then `out` = 5 (`last` = 1); `in_ready` = 0 for the 2 beat cycles, returns to 1 after.
2. Loop i = 0..7 with `in` = 1<<i, one vector at a time -> single beat each, `out` = i, `out_last` = 1, `out_none` = 0. Feed `out` into `decoder` -> its output equals 1<<i.
3. `in` = 8'h00 -> one beat with `out` = 0, `out_none` = 1, `out_last` = 1, then back to IDLE.
4. `in` = 8'hFF with `out_ready` toggling 1,0,0,1,... -> indices 0..7 in order, no beat skipped or repeated, outputs stable during every stall cycle.
5. `in` = 8'b1000_0001 accepted; change `in` to 8'h3C during SCAN while `in_valid` is high -> beats 0 then 7 only. 8'h3C is accepted only after return to IDLE, giving beats 2, 3, 4, 5.
6. `in` = 8'hF0 accepted, `rst` asserted after the first beat (index 4) -> next cycle `out_valid` = 0, `in_ready` = 0 while `rst` is high. After release `in_ready` = 1 and no indices 5..7 ever appear.
